// File: rtl/iq_stream_pkg.sv
// iq_stream_pkg: shared types and widths for the IQ stream framer.
//   iq_sample_t : packed {i, q} sample, I in the upper half of the bus word
//   pkt_state_t : framer packet state (IDLE at a packet boundary, IN_PKT otherwise)
//   sat_inc     : saturating increment for the 32-bit statistics counters
package iq_stream_pkg;

    localparam int unsigned IQ_COMP_W = 16;
    localparam int unsigned IQ_WORD_W = 32;
    localparam int unsigned COUNT_W   = 32;

    typedef struct packed {
        logic signed [IQ_COMP_W-1:0] i;
        logic signed [IQ_COMP_W-1:0] q;
    } iq_sample_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// iq_sync_fifo: single-clock first-word-fall-through FIFO with registered
// read data, registered full/empty flags and 2^DEPTH_LOG2 entries.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write request (ignored when full unless a pop happens too)
//   i_wdata   : write data
//   i_pop     : read request (ignored when empty)
//   o_full    : FIFO holds 2^DEPTH_LOG2 entries
//   o_empty   : FIFO holds no entries
//   o_rdata   : current head entry, valid whenever !o_empty
module iq_sync_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_rdata;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign w_do_pop     = i_pop && !r_empty;
    assign w_do_push    = i_push && (!r_full || w_do_pop);
    assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_do_push);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_do_pop);

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wdata;
        end
    end

    // Pointers, flags and the registered head word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_rdata  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_full   <= (w_wr_ptr_nxt[DEPTH_LOG2] != w_rd_ptr_nxt[DEPTH_LOG2]) &&
                        (w_wr_ptr_nxt[DEPTH_LOG2-1:0] == w_rd_ptr_nxt[DEPTH_LOG2-1:0]);
            // New head is the word being written when the FIFO is momentarily
            // empty after the pop; otherwise it already sits in the array.
            if (w_wr_ptr_nxt != w_rd_ptr_nxt) begin
                if (w_rd_ptr_nxt == r_wr_ptr) begin
                    r_rdata <= i_wdata;
                end else begin
                    r_rdata <= r_mem[w_rd_ptr_nxt[DEPTH_LOG2-1:0]];
                end
            end
        end
    end

    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/iq_stream_framer.sv
// iq_stream_framer: frames a non-backpressurable I/Q sample strobe into
// AXI-Stream packets of {I,Q} words with tlast every spp samples. A FIFO of
// 2^DEPTH_LOG2 samples absorbs downstream backpressure; samples arriving at
// a full FIFO are dropped and flagged, the source is never stalled.
// Optional feature macro: IQ_STREAM_FRAMER_STATS_EN builds the drop and frame
// counters; without it drop_count and frame_count are tied to 0.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_stb/in_i/in_q  : sample strobe and signed I/Q components
//   spp               : samples per packet, sampled at each packet start (0 acts as 1)
//   m_tdata/m_tvalid/m_tready/m_tlast : AXI-Stream master, I in tdata[31:16]
//   overflow          : sticky drop flag, cleared by clr_overflow
//   clr_overflow      : clears overflow and drop_count
//   drop_count        : dropped samples (saturating)
//   frame_count       : completed packets (saturating)
import iq_stream_pkg::*;

module iq_stream_framer #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned SPP_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_stb,
    input  logic [IQ_COMP_W-1:0] in_i,
    input  logic [IQ_COMP_W-1:0] in_q,
    input  logic [SPP_W-1:0]     spp,
    output logic [IQ_WORD_W-1:0] m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 overflow,
    input  logic                 clr_overflow,
    output logic [COUNT_W-1:0]   drop_count,
    output logic [COUNT_W-1:0]   frame_count
);

    iq_sample_t           w_in_sample;
    logic [IQ_WORD_W-1:0] w_in_word;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_xfer;
    logic                 w_drop;

    pkt_state_t           r_state;
    pkt_state_t           w_state_nxt;
    logic [SPP_W-1:0]     r_beat;
    logic [SPP_W-1:0]     w_beat_nxt;
    logic [SPP_W-1:0]     r_cur_spp;
    logic [SPP_W-1:0]     w_live_spp;
    logic [SPP_W-1:0]     w_eff_spp;
    logic                 w_last;
    logic                 r_overflow;

    assign w_in_sample.i = in_i;
    assign w_in_sample.q = in_q;
    assign w_in_word     = w_in_sample;

    iq_sync_fifo #(
        .WIDTH      (IQ_WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_stb),
        .i_wdata (w_in_word),
        .i_pop   (m_tready),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_rdata (m_tdata)
    );

    assign m_tvalid = !w_fifo_empty;
    assign w_xfer   = m_tvalid && m_tready;
    assign w_drop   = in_stb && w_fifo_full && !w_xfer;

    // Packet length: live spp at a packet boundary, latched value mid-packet.
    assign w_live_spp = (spp == '0) ? SPP_W'(1) : spp;
    assign w_eff_spp  = (r_state == ST_IDLE) ? w_live_spp : r_cur_spp;
    assign w_last     = (r_beat == w_eff_spp - SPP_W'(1));
    assign m_tlast    = m_tvalid && w_last;

    // Packet state and beat counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_cur_spp <= SPP_W'(1);
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_xfer && (r_state == ST_IDLE)) begin
                r_cur_spp <= w_live_spp;
            end
        end
    end

    // Next packet state: advance on each transfer, close on tlast.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        if (w_xfer) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = '0;
            end else begin
                w_state_nxt = ST_IN_PKT;
                w_beat_nxt  = r_beat + SPP_W'(1);
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

`ifdef IQ_STREAM_FRAMER_STATS_EN
    logic [COUNT_W-1:0] r_drop_count;
    logic [COUNT_W-1:0] r_frame_count;

    // Saturating statistics; a clear coinciding with a drop restarts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count  <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_drop) begin
                r_drop_count <= clr_overflow ? COUNT_W'(1) : sat_inc(r_drop_count);
            end else if (clr_overflow) begin
                r_drop_count <= '0;
            end
            if (w_xfer && w_last) begin
                r_frame_count <= sat_inc(r_frame_count);
            end
        end
    end

    assign drop_count  = r_drop_count;
    assign frame_count = r_frame_count;
`else
    assign drop_count  = '0;
    assign frame_count = '0;
`endif

endmodule

// File: doc/iq_stream_framer.md
# iq_stream_framer

Synthesizable stage directly downstream of the testbench IQ file reader: accepts one 16-bit I/Q sample per strobe from a non-backpressurable source (file reader in simulation, radio front end in hardware) and emits RFNoC-style AXI-Stream packets of `{I,Q}` words with `tlast` every `spp` samples. An internal FIFO absorbs output backpressure. Overflow drops samples and counts them; it never stalls the source.

## Interface
- `DEPTH_LOG2`, default 5: FIFO depth is 2^DEPTH_LOG2 samples.
- `SPP_W`, default 16: width of the samples-per-packet control.
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `in_stb` in 1: sample strobe. No ready is returned.
- `in_i` in 16: signed I sample, valid with `in_stb`.
- `in_q` in 16: signed Q sample, valid with `in_stb`.
- `spp` in SPP_W: samples per packet. Sampled at the first beat of each packet.
- `m_tdata` out 32: `{I[15:0], Q[15:0]}`, with I in the upper half.
- `m_tvalid` out 1: output data valid.
- `m_tready` in 1: downstream ready.
- `m_tlast` out 1: last beat of the packet.
- `overflow` out 1: sticky flag, set by any dropped sample.
- `clr_overflow` in 1: clears `overflow` (and `drop_count` when stats are enabled).
- `drop_count` out 32: number of dropped samples.
- `frame_count` out 32: number of completed packets.

## Operation
- Write side: on `in_stb`, push `{in_i,in_q}` into the FIFO when not full, or when full and a pop occurs in the same cycle. Otherwise drop the sample and set `overflow`.
- Read side: `m_tvalid` = FIFO non-empty. A beat transfers when `m_tvalid && m_tready`.
- Packet counter `beat` (SPP_W bits), plus `cur_spp` latched when `beat==0` and a transfer occurs.
  - `spp==0` is treated as 1.
  - `m_tlast` = `(beat == eff_spp-1)`, where `eff_spp` is the live `spp` when `beat==0`, else `cur_spp`.
  - On a transfer with `m_tlast`, `beat` returns to 0 and `frame_count` increments. Otherwise `beat` increments.
- Changing `spp` mid-packet has no effect until the next packet starts.
- State machine, 2 states:
  - IDLE (`beat==0`) → IN_PKT on a transfer without `tlast`.
  - IN_PKT → IDLE on a transfer with `tlast`.
  - A transfer with `tlast` in IDLE (spp≤1) stays in IDLE.
- Counters saturate at 2^32-1.
- `clr_overflow` and a new drop in the same cycle: the drop wins, so `overflow`=1 and `drop_count`=1.
- Reset mid-packet discards FIFO contents and the partial packet. The next beat after reset starts a new packet.

## Timing
- Latency: a sample strobed in cycle N is first visible on `m_tdata`/`m_tvalid` in cycle N+1.
- Throughput: 1 sample/cycle sustained while `m_tready`=1.
- FIFO full is reached at 2^DEPTH_LOG2 entries. A push into a full FIFO with a simultaneous pop is accepted with no drop.
- `m_tdata`/`m_tlast` are held stable while `m_tvalid && !m_tready`.
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `overflow`=0, `drop_count`=0, `frame_count`=0. FIFO is empty and `beat`=0.
- All control pointers wrap modulo 2^DEPTH_LOG2, with an extra MSB for the full/empty distinction.

## Configuration
- Macro: `IQ_STREAM_FRAMER_STATS_EN`.
- Defined: `drop_count` and `frame_count` are live 32-bit saturating counters.
- Undefined: both ports are tied to 0 and no counter logic is built. `overflow` and framing are unaffected.

## Structure
- Shared package `iq_stream_pkg`:
  - packed `iq_sample_t` `{logic signed [15:0] i, q}`
  - `IQ_WORD_W=32`
  - `COUNT_W=32`
- Sub-module `iq_sync_fifo`: single-clock FIFO with push, pop, full, empty and registered read data, parameterized by width and DEPTH_LOG2.
- The top level holds the packet counter, the 2-state FSM, the overflow logic and the stats counters.

## Test plan
- **Basic framing:** spp=4, `m_tready`=1, strobe 8 samples I=1..8, Q=-1..-8 → 8 beats. `m_tdata[31:16]`=1..8 and `m_tdata[15:0]`=0xFFFF..0xFFF8. `tlast` on beats 4 and 8. `frame_count`=2.
- **Backpressure, no loss:** `m_tready`=0 for 20 cycles while strobing 20 samples (DEPTH_LOG2=5), then `m_tready`=1 → all 20 delivered in order. `overflow`=0.
- **Overflow:** `m_tready`=0, strobe 40 samples → 32 stored, `drop_count`=8, `overflow`=1. Then assert `clr_overflow` with no drop → `overflow`=0, `drop_count`=0.
- **Full with simultaneous push and pop:** fill to 32, then strobe and pulse `m_tready` in the same cycle for 10 cycles → no drops. Occupancy stays 32.
- **spp change mid-packet:** spp=4, change to 2 after beat 2 → `tlast` on beat 4, then on beats 6 and 8. spp=0 → `tlast` on every beat.
- **Reset mid-packet:** assert `rst` after 3 of 4 beats → all outputs return to reset values. The next 4 samples form a complete packet with `tlast` on the 4th beat.
